uart_exchange_sequencer: RTL and testbench

Command-level controller for the half-duplex UART core. A host issues one command: send N bytes, then receive M bytes. The block then sequences the UART: it loads each TX byte with startTx, inserts inter-byte guard time, turns the line around to RX, acknowledges every received byte and enforces a per-byte waiting-time timeout. It sits between the host/register interface and the UART core's flag/data ports.

---
 rtl/uart_exchange_sequencer_if.sv | 42 ++++
 rtl/uart_exchange_sequencer.sv | 168 ++++++++++++++++
 tb/tb_uart_exchange_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_exchange_sequencer_if.sv
// Signal bundle between uart_exchange_sequencer (slave modport) and its host,
// byte source/sink and the half-duplex UART core (master modport).
interface uart_exchange_sequencer_if #(
    parameter int LEN_WIDTH   = 8,
    parameter int GUARD_WIDTH = 8,
    parameter int WAIT_WIDTH  = 16
);
    logic                   cmdStart;
    logic [LEN_WIDTH-1:0]   cmdTxLen;
    logic [LEN_WIDTH-1:0]   cmdRxLen;
    logic [GUARD_WIDTH-1:0] guardCycles;
    logic [WAIT_WIDTH-1:0]  waitCycles;
    logic                   busy, done, timeoutErr, frameErr, overrunErr;
    logic [7:0]             srcData;
    logic                   srcValid, srcReady;
    logic [7:0]             rxByte;
    logic                   rxValid;
    logic [7:0]             uartTxData;
    logic                   uartStartTx, uartAckFlags;
    logic                   uartTxFull, uartTxRun;
    logic [7:0]             uartRxData;
    logic                   uartDataReady, uartFrameError, uartOverrun;
    logic                   uartRxStartBit, uartRxRun;

    modport slave (
        input  cmdStart, cmdTxLen, cmdRxLen, guardCycles, waitCycles,
        input  srcData, srcValid,
        input  uartTxFull, uartTxRun, uartRxData, uartDataReady,
        input  uartFrameError, uartOverrun, uartRxStartBit, uartRxRun,
        output busy, done, timeoutErr, frameErr, overrunErr,
        output srcReady, rxByte, rxValid, uartTxData, uartStartTx, uartAckFlags
    );

    modport master (
        output cmdStart, cmdTxLen, cmdRxLen, guardCycles, waitCycles,
        output srcData, srcValid,
        output uartTxFull, uartTxRun, uartRxData, uartDataReady,
        output uartFrameError, uartOverrun, uartRxStartBit, uartRxRun,
        input  busy, done, timeoutErr, frameErr, overrunErr,
        input  srcReady, rxByte, rxValid, uartTxData, uartStartTx, uartAckFlags
    );
endinterface

// File: rtl/uart_exchange_sequencer.sv
// Command sequencer for a half-duplex UART: send N bytes with guard time, then receive M bytes
// with a per-byte wait timeout. Optional macro SEQ_RX_FRAME_DROP_EN drops frame-errored RX bytes.
module uart_exchange_sequencer #(
    parameter int LEN_WIDTH   = 8,
    parameter int GUARD_WIDTH = 8,
    parameter int WAIT_WIDTH  = 16
) (
    input logic                      clk,
    input logic                      reset,
    uart_exchange_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, TX_FETCH, TX_LOAD, TX_WAIT, GUARD, RX_WAIT, RX_ACK, DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   tx_rem_q, tx_rem_d, rx_rem_q, rx_rem_d;
    logic [GUARD_WIDTH-1:0] guard_cnt_q, guard_cnt_d;
    logic [GUARD_WIDTH:0]   guard_next;
    logic [WAIT_WIDTH-1:0]  wait_cnt_q, wait_cnt_d, wait_next;
    logic [7:0]             tx_data_q, tx_data_d, rx_byte_q, rx_byte_d;
    logic busy_q, busy_d, done_q, done_d, rx_valid_q, rx_valid_d;
    logic start_tx_q, start_tx_d, ack_q, ack_d, src_ready_q, src_ready_d;
    logic timeout_q, timeout_d, frame_q, frame_d, overrun_q, overrun_d;
    logic keep_byte;

`ifdef SEQ_RX_FRAME_DROP_EN
    // A framed-bad byte leaves its slot open for the card's retransmission.
    assign keep_byte = ~bus.uartFrameError;
`else
    assign keep_byte = 1'b1;
`endif

    assign guard_next = {1'b0, guard_cnt_q} + (GUARD_WIDTH+1)'(1);
    // Waiting time only runs while the line is quiet; it saturates rather than wrapping.
    assign wait_next  = (!bus.uartRxStartBit && !bus.uartRxRun && wait_cnt_q != '1)
                        ? wait_cnt_q + WAIT_WIDTH'(1) : wait_cnt_q;

    always_comb begin
        state_d     = state_q;
        tx_rem_d    = tx_rem_q;
        rx_rem_d    = rx_rem_q;
        guard_cnt_d = guard_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        tx_data_d   = tx_data_q;
        rx_byte_d   = rx_byte_q;
        timeout_d   = timeout_q;
        frame_d     = frame_q;
        overrun_d   = overrun_q;
        rx_valid_d  = 1'b0;
        done_d      = 1'b0;
        case (state_q)
            IDLE: if (bus.cmdStart) begin
                tx_rem_d   = bus.cmdTxLen;
                rx_rem_d   = bus.cmdRxLen;
                timeout_d  = 1'b0;
                frame_d    = 1'b0;
                overrun_d  = 1'b0;
                wait_cnt_d = '0;
                if (bus.cmdTxLen != '0)      state_d = TX_FETCH;
                else if (bus.cmdRxLen != '0) state_d = RX_WAIT;
                else                         state_d = DONE;
            end
            TX_FETCH: if (bus.srcValid) begin
                tx_data_d = bus.srcData;
                state_d   = TX_LOAD;
            end
            TX_LOAD: if (bus.uartTxFull || bus.uartTxRun) state_d = TX_WAIT;
            TX_WAIT: if (!bus.uartTxFull && !bus.uartTxRun) begin
                tx_rem_d    = tx_rem_q - LEN_WIDTH'(1);
                guard_cnt_d = '0;
                state_d     = GUARD;
            end
            GUARD: begin
                if (guard_next >= {1'b0, bus.guardCycles}) begin
                    if (tx_rem_q != '0) state_d = TX_FETCH;
                    else if (rx_rem_q != '0) begin
                        wait_cnt_d = '0;
                        state_d    = RX_WAIT;
                    end else state_d = DONE;
                end else guard_cnt_d = guard_next[GUARD_WIDTH-1:0];
            end
            RX_WAIT: begin
                if (bus.uartDataReady) begin
                    rx_byte_d = bus.uartRxData;
                    state_d   = RX_ACK;
                end else begin
                    wait_cnt_d = wait_next;
                    if (bus.waitCycles != '0 && wait_next >= bus.waitCycles) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end
                end
            end
            RX_ACK: begin
                frame_d    = frame_q | bus.uartFrameError;
                overrun_d  = overrun_q | bus.uartOverrun;
                wait_cnt_d = '0;
                state_d    = RX_WAIT;
                if (keep_byte) begin
                    rx_valid_d = 1'b1;
                    rx_rem_d   = rx_rem_q - LEN_WIDTH'(1);
                    if (rx_rem_q == LEN_WIDTH'(1)) state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Moore outputs registered off the next state so they line up with the state itself.
        busy_d      = (state_d != IDLE);
        src_ready_d = (state_d == TX_FETCH);
        start_tx_d  = (state_d == TX_LOAD);
        ack_d       = (state_d == RX_ACK);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            tx_rem_q    <= '0;
            rx_rem_q    <= '0;
            guard_cnt_q <= '0;
            wait_cnt_q  <= '0;
            tx_data_q   <= '0;
            rx_byte_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rx_valid_q  <= 1'b0;
            start_tx_q  <= 1'b0;
            ack_q       <= 1'b0;
            src_ready_q <= 1'b0;
            timeout_q   <= 1'b0;
            frame_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tx_rem_q    <= tx_rem_d;
            rx_rem_q    <= rx_rem_d;
            guard_cnt_q <= guard_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            tx_data_q   <= tx_data_d;
            rx_byte_q   <= rx_byte_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rx_valid_q  <= rx_valid_d;
            start_tx_q  <= start_tx_d;
            ack_q       <= ack_d;
            src_ready_q <= src_ready_d;
            timeout_q   <= timeout_d;
            frame_q     <= frame_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.timeoutErr   = timeout_q;
    assign bus.frameErr     = frame_q;
    assign bus.overrunErr   = overrun_q;
    assign bus.srcReady     = src_ready_q;
    assign bus.rxByte       = rx_byte_q;
    assign bus.rxValid      = rx_valid_q;
    assign bus.uartTxData   = tx_data_q;
    assign bus.uartStartTx  = start_tx_q;
    assign bus.uartAckFlags = ack_q;
endmodule

// File: tb/tb_uart_exchange_sequencer.sv
// Scoreboard bench for uart_exchange_sequencer: directed scenarios plus randomized commands
// against behavioural UART/host models; honours SEQ_RX_FRAME_DROP_EN.
module tb_uart_exchange_sequencer;
    localparam int LW = 8, GW = 8, WW = 16;
`ifdef SEQ_RX_FRAME_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    typedef struct { logic [7:0] data; bit fe; bit ov; int dly; int run; } rx_item_t;
    typedef struct { bit te; bit fe; bit ov; int lat; int cmd_cyc; } done_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    uart_exchange_sequencer_if #(.LEN_WIDTH(LW), .GUARD_WIDTH(GW), .WAIT_WIDTH(WW)) bus ();
    uart_exchange_sequencer #(.LEN_WIDTH(LW), .GUARD_WIDTH(GW), .WAIT_WIDTH(WW)) dut (
        .clk(clk), .reset(reset), .bus(bus.slave));

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int tx_seen = 0, cur_txl = 0, cur_guard = 0, fall_cyc = 0;
    bit gap_armed = 0, rx_busy = 0;
    logic [7:0] exp_tx[$], exp_rx[$], src_q[$], stage_tx[$];
    rx_item_t   rx_q[$], stage_rx[$];
    done_t      exp_done[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: expected TX order, delivered RX bytes and final flags from the staged command.
    task automatic issue(input int rxl, input int g, input int w, input int lat);
        done_t d;
        int deliv = 0;
        d.te = 0; d.fe = 0; d.ov = 0; d.lat = lat;
        foreach (stage_tx[i]) begin
            exp_tx.push_back(stage_tx[i]);
            src_q.push_back(stage_tx[i]);
        end
        foreach (stage_rx[i]) begin
            d.fe |= stage_rx[i].fe;
            d.ov |= stage_rx[i].ov;
            if (!(DROP && stage_rx[i].fe)) begin
                exp_rx.push_back(stage_rx[i].data);
                deliv++;
            end
            rx_q.push_back(stage_rx[i]);
        end
        d.te = (deliv < rxl);
        tx_seen = 0; cur_txl = stage_tx.size(); cur_guard = g; gap_armed = 0;
        bus.cmdTxLen = LW'(stage_tx.size()); bus.cmdRxLen = LW'(rxl);
        bus.guardCycles = GW'(g); bus.waitCycles = WW'(w);
        bus.cmdStart = 1'b1;
        d.cmd_cyc = cyc;
        exp_done.push_back(d);
        @(posedge clk); #1 bus.cmdStart = 1'b0;
        stage_tx.delete(); stage_rx.delete();
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_done.size() != 0 || bus.busy || rx_q.size() != 0 || rx_busy ||
                bus.uartTxRun || bus.uartTxFull) && k < 3000) begin
            @(negedge clk); k++;
        end
        if (k >= 3000) chk("drain_bound_expired", 1, 0);
        @(posedge clk); #1;
    endtask

    function automatic rx_item_t mk(input logic [7:0] data, input bit fe, input int dly, input int run);
        rx_item_t it;
        it.data = data; it.fe = fe; it.ov = 1'b0; it.dly = dly; it.run = run;
        return it;
    endfunction

    // Byte source: holds srcValid until the handshake completes.
    initial begin : src_drv
        bit hs;
        forever begin
            @(negedge clk); hs = bus.srcValid && bus.srcReady;
            @(posedge clk); #1;
            if (hs) begin void'(src_q.pop_front()); bus.srcValid = 1'b0; end
            if (!bus.srcValid && src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
                bus.srcValid = 1'b1; bus.srcData = src_q[0];
            end
        end
    end

    // UART transmitter: one cycle of txFull, then txRun for a few cycles.
    initial begin : tx_model
        forever begin
            @(negedge clk);
            if (bus.uartStartTx && !reset) begin
                @(posedge clk); #1 bus.uartTxFull = 1'b1;
                @(posedge clk); #1 bus.uartTxFull = 1'b0; bus.uartTxRun = 1'b1;
                repeat ($urandom_range(1, 6)) @(posedge clk);
                #1 bus.uartTxRun = 1'b0;
            end
        end
    end

    // UART receiver: after the TX phase, per item: idle, start bit, run, then flags until acked.
    initial begin : rx_model
        rx_item_t it;
        int k;
        forever begin
            @(negedge clk);
            if (rx_q.size() > 0 && tx_seen >= cur_txl && !bus.uartStartTx &&
                !bus.uartTxRun && !bus.uartTxFull) begin
                rx_busy = 1;
                it = rx_q.pop_front();
                repeat (it.dly) @(posedge clk);
                @(posedge clk); #1 bus.uartRxStartBit = 1'b1;
                @(posedge clk); #1 bus.uartRxStartBit = 1'b0; bus.uartRxRun = 1'b1;
                repeat (it.run) @(posedge clk);
                #1 bus.uartRxRun = 1'b0; bus.uartDataReady = 1'b1; bus.uartRxData = it.data;
                bus.uartFrameError = it.fe; bus.uartOverrun = it.ov;
                k = 0;
                do begin @(negedge clk); k++; end while (!bus.uartAckFlags && k < 2000);
                if (k >= 2000) chk("ack_bound_expired", 0, 1);
                @(posedge clk); #1 bus.uartDataReady = 1'b0; bus.uartFrameError = 1'b0;
                bus.uartOverrun = 1'b0;
                rx_busy = 0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a TX load, RX byte or completion.
    bit prev_start = 0, prev_ack = 0, prev_txbusy = 0, prev_ready = 0;
    always @(negedge clk) begin
        done_t d;
        if (!reset) begin
            if (bus.uartStartTx && !prev_start) begin
                tx_seen++;
                if (exp_tx.size() == 0) chk("tx_unexpected", 1, 0);
                else chk("tx_byte", bus.uartTxData, exp_tx.pop_front());
            end
            if (bus.uartAckFlags) chk("ack_width", prev_ack, 0);
            if (bus.rxValid) begin
                if (exp_rx.size() == 0) chk("rx_unexpected", 1, 0);
                else chk("rx_byte", bus.rxByte, exp_rx.pop_front());
            end
            if (prev_txbusy && !bus.uartTxRun && !bus.uartTxFull) begin
                gap_armed = 1; fall_cyc = cyc;
            end
            if (bus.srcReady && !prev_ready && gap_armed) begin
                chk("guard_gap", cyc - fall_cyc, ((cur_guard == 0) ? 1 : cur_guard) + 1);
                gap_armed = 0;
            end
            if (bus.done) begin
                gap_armed = 0;
                if (exp_done.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    d = exp_done.pop_front();
                    chk("busy_at_done", bus.busy, 0);
                    chk("timeoutErr", bus.timeoutErr, d.te);
                    chk("frameErr", bus.frameErr, d.fe);
                    chk("overrunErr", bus.overrunErr, d.ov);
                    if (d.lat >= 0) chk("done_latency", cyc - d.cmd_cyc, d.lat);
                    chk("tx_left_at_done", exp_tx.size(), 0);
                    chk("rx_left_at_done", exp_rx.size(), 0);
                end
            end
        end
        prev_start  = bus.uartStartTx;
        prev_ack    = bus.uartAckFlags;
        prev_txbusy = bus.uartTxRun | bus.uartTxFull;
        prev_ready  = bus.srcReady;
    end

    initial begin : watchdog
        #800000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin : main
        rx_item_t it;
        int txl, rxl, g, w, deliv, k;
        bus.cmdStart = 0; bus.cmdTxLen = 0; bus.cmdRxLen = 0; bus.guardCycles = 0;
        bus.waitCycles = 0; bus.srcData = 0; bus.srcValid = 0; bus.uartTxFull = 0;
        bus.uartTxRun = 0; bus.uartRxData = 0; bus.uartDataReady = 0;
        bus.uartFrameError = 0; bus.uartOverrun = 0; bus.uartRxStartBit = 0; bus.uartRxRun = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_flags", {bus.timeoutErr, bus.frameErr, bus.overrunErr}, 0);
        chk("rst_strobes", {bus.srcReady, bus.rxValid, bus.uartStartTx, bus.uartAckFlags}, 0);
        @(posedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;

        // TX only with guard time
        stage_tx = '{8'h3B, 8'h11, 8'hA5};
        issue(0, 4, 0, -1); drain();

        // TX then RX turnaround
        stage_tx = '{8'hC0};
        stage_rx.push_back(mk(8'h90, 0, 2, 3));
        stage_rx.push_back(mk(8'h00, 0, 1, 2));
        issue(2, 2, 0, -1); drain();

        // Waiting-time expiry: RX_WAIT entered the cycle after cmdStart
        issue(1, 0, 50, 52); drain();

        // Start bit at ~40 cycles freezes the timer; no timeout
        stage_rx.push_back(mk(8'h5E, 0, 40, 30));
        issue(1, 0, 50, -1); drain();

        // First byte frame-errored
        stage_rx.push_back(mk(8'hA1, 1, 1, 2));
        stage_rx.push_back(mk(8'hB2, 0, 1, 2));
        if (DROP) stage_rx.push_back(mk(8'hC3, 0, 1, 2));
        issue(2, 0, 0, -1); drain();

        // Reset during TX_LOAD
        stage_tx = '{8'h6D};
        issue(0, 0, 0, -1);
        k = 0;
        while (!bus.uartStartTx && k < 200) begin @(negedge clk); k++; end
        if (k >= 200) chk("load_bound_expired", 1, 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_startTx", bus.uartStartTx, 0);
        chk("midrst_flags", {bus.done, bus.timeoutErr, bus.frameErr, bus.overrunErr}, 0);
        exp_done.delete(); exp_tx.delete(); src_q.delete();
        @(posedge clk); #1 reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;

        // Empty command; a second cmdStart while busy is ignored
        issue(0, 0, 0, 2);
        bus.cmdStart = 1'b1; bus.cmdTxLen = 5; bus.cmdRxLen = 3;
        @(posedge clk); #1 bus.cmdStart = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("ignored_cmd_busy", bus.busy, 0);
        drain();

        // Randomized commands
        for (int n = 0; n < 25; n++) begin
            txl = $urandom_range(0, 4);
            rxl = $urandom_range(0, 3);
            g   = $urandom_range(0, 5);
            w   = ($urandom_range(0, 1) == 0) ? 0 : 400;
            for (int i = 0; i < txl; i++) stage_tx.push_back(8'($urandom_range(0, 255)));
            deliv = 0;
            while (deliv < rxl) begin
                it = mk(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                        $urandom_range(0, 6), $urandom_range(1, 4));
                it.ov = ($urandom_range(0, 7) == 0);
                stage_rx.push_back(it);
                if (!(DROP && it.fe)) deliv++;
            end
            issue(rxl, g, w, -1); drain();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
